// File: rtl/auth_cmd_tx.sv
// auth_cmd_tx: transmit end of the rider-authorization link.
// Turns GO/STOP request pulses into 8N1 UART frames carrying 0x67 ('g') or 0x73 ('s').
// A one-deep pending slot holds the next command, and STOP wins a same-cycle tie.
// The block also tracks the last command that was delivered.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   go_req    one-cycle pulse, request a GO (0x67) frame
//   stop_req  one-cycle pulse, request a STOP (0x73) frame
//   TX        serial line, idle high, driven straight from a flop
//   busy      high while a frame is on the line
//   sent      one-cycle pulse during the final cycle of each stop bit
//   pwr_st    1 after a GO frame completes, 0 after a STOP frame completes
//
// Optional feature: define AUTH_TX_KEEPALIVE_EN to re-send GO automatically after
// KA_PERIOD idle cycles while pwr_st=1.
module auth_cmd_tx #(
   parameter int unsigned BAUD_DIV  = 5208,
   parameter int unsigned KA_PERIOD = 1048576
) (
   input  logic clk,
   input  logic rst_n,
   input  logic go_req,
   input  logic stop_req,
   output logic TX,
   output logic busy,
   output logic sent,
   output logic pwr_st
);

   localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BaudLast = BW'(BAUD_DIV - 1);
   localparam logic [7:0] GoByte   = 8'h67;
   localparam logic [7:0] StopByte = 8'h73;

   if (BAUD_DIV < 2) begin : g_bad_baud
      $error("auth_cmd_tx: BAUD_DIV must be at least 2");
   end
   if (KA_PERIOD < 1) begin : g_bad_ka
      $error("auth_cmd_tx: KA_PERIOD must be at least 1");
   end

   typedef enum logic {StIdle, StXmit} state_e;

   state_e        state_q, state_d;
   logic [9:0]    shift_q, shift_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic          slot_vld_q, slot_vld_d;
   logic          slot_go_q, slot_go_d;
   logic          cur_go_q, cur_go_d;
   logic          pwr_q, pwr_d;

   logic          ka_fire;
   logic          wr_vld;
   logic          wr_go;
   logic          frame_end;
   logic          nxt_go;

   assign frame_end = (state_q == StXmit) && (bit_q == 4'd9) && (baud_q == BaudLast);
   assign sent      = frame_end;
   assign busy      = (state_q == StXmit);
   assign TX        = shift_q[0];
   assign pwr_st    = pwr_q;

   // User requests beat the keepalive and STOP beats GO, so GO is written only
   // when no STOP is present.
   assign wr_vld = go_req | stop_req | ka_fire;
   assign wr_go  = ~stop_req;

`ifdef AUTH_TX_KEEPALIVE_EN
   localparam int unsigned KW = (KA_PERIOD > 1) ? $clog2(KA_PERIOD) : 1;
   localparam logic [KW-1:0] KaLast = KW'(KA_PERIOD - 1);

   logic [KW-1:0] ka_q, ka_d;
   logic          ka_run;

   always_comb begin
      ka_run  = pwr_q && (state_q == StIdle) && !slot_vld_q;
      ka_fire = ka_run && (ka_q == KaLast);
      ka_d    = ka_q;
      if (sent || go_req || stop_req || !pwr_q) begin
         ka_d = '0;
      end else if (ka_run) begin
         ka_d = ka_fire ? '0 : ka_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ka_q <= '0;
      end else begin
         ka_q <= ka_d;
      end
   end
`else
   assign ka_fire = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      slot_vld_d = slot_vld_q;
      slot_go_d  = slot_go_q;
      cur_go_d   = cur_go_q;
      pwr_d      = pwr_q;
      nxt_go     = 1'b0;

      // A newer request always overwrites an unsent one.
      if (wr_vld) begin
         slot_vld_d = 1'b1;
         slot_go_d  = wr_go;
      end

      unique case (state_q)
         StIdle: begin
            if (slot_vld_q) begin
               nxt_go     = slot_go_q;
               shift_d    = {1'b1, (nxt_go ? GoByte : StopByte), 1'b0};
               cur_go_d   = nxt_go;
               baud_d     = '0;
               bit_d      = 4'd0;
               slot_vld_d = wr_vld;
               state_d    = StXmit;
            end
         end
         StXmit: begin
            if (baud_q == BaudLast) begin
               baud_d  = '0;
               // Ones shift in behind the frame, which leaves the line idle-high.
               shift_d = {1'b1, shift_q[9:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_q == 4'd9) begin
                  pwr_d = cur_go_q;
                  bit_d = 4'd0;
                  // A request landing on the frame-end edge goes out back-to-back.
                  if (wr_vld || slot_vld_q) begin
                     nxt_go     = wr_vld ? wr_go : slot_go_q;
                     shift_d    = {1'b1, (nxt_go ? GoByte : StopByte), 1'b0};
                     cur_go_d   = nxt_go;
                     slot_vld_d = 1'b0;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         shift_q    <= '1;
         baud_q     <= '0;
         bit_q      <= 4'd0;
         slot_vld_q <= 1'b0;
         slot_go_q  <= 1'b0;
         cur_go_q   <= 1'b0;
         pwr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         slot_vld_q <= slot_vld_d;
         slot_go_q  <= slot_go_d;
         cur_go_q   <= cur_go_d;
         pwr_q      <= pwr_d;
      end
   end

endmodule
